// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the write-arbiter state type.
package fb_pkg;

  localparam int FB_WIDTH  = 128;
  localparam int FB_HEIGHT = 64;
  localparam int FB_X_W    = 8;
  localparam int FB_Y_W    = 8;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester-side and framebuffer-side signals of the write arbiter; req_err exists only with FB_ARB_TIMEOUT_EN.
interface fb_write_arbiter_if
  import fb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_W     = FB_X_W,
  parameter int Y_W     = FB_Y_W,
  parameter int DATA_W  = FB_DATA_W
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*X_W-1:0]    req_xpos;
  logic [NUM_REQ*Y_W-1:0]    req_ypos;
  logic [NUM_REQ*DATA_W-1:0] req_din;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      fb_we;
  logic [X_W-1:0]            fb_w_xpos;
  logic [Y_W-1:0]            fb_w_ypos;
  logic [DATA_W-1:0]         fb_din;
  logic                      fb_w_data_valid;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;
`ifdef FB_ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0]        req_err;
`endif

  modport master (
    input  req_valid, req_xpos, req_ypos, req_din, fb_w_data_valid,
    output req_ack, fb_we, fb_w_xpos, fb_w_ypos, fb_din, busy, grant_id
`ifdef FB_ARB_TIMEOUT_EN
    , output req_err
`endif
  );

  modport slave (
    output req_valid, req_xpos, req_ypos, req_din, fb_w_data_valid,
    input  req_ack, fb_we, fb_w_xpos, fb_w_ypos, fb_din, busy, grant_id
`ifdef FB_ARB_TIMEOUT_EN
    , input req_err
`endif
  );

endinterface

// File: rtl/fb_write_arbiter_rr_priority_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port; one write in flight at a time.
// Optional watchdog on the ISSUE state enabled by defining FB_ARB_TIMEOUT_EN.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int X_W            = FB_X_W,
  parameter int Y_W            = FB_Y_W,
  parameter int DATA_W         = FB_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  fb_write_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fb_write_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES positive");
  end

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic                we_q, we_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    gid_q, gid_d;
  logic                found;
  logic [IDX_W-1:0]    pick;

`ifdef FB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
`endif

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
  endfunction

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_q),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    we_d    = we_q;
    x_d     = x_q;
    y_d     = y_q;
    din_d   = din_q;
    ack_d   = '0;
    busy_d  = busy_q;
    gid_d   = gid_q;
`ifdef FB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        // A completion strobe seen here is spurious and deliberately ignored.
        if (found) begin
          x_d     = bus.req_xpos[pick*X_W +: X_W];
          y_d     = bus.req_ypos[pick*Y_W +: Y_W];
          din_d   = bus.req_din[pick*DATA_W +: DATA_W];
          we_d    = 1'b1;
          gid_d   = pick;
          busy_d  = 1'b1;
          state_d = ISSUE;
`ifdef FB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (bus.fb_w_data_valid) begin
          we_d         = 1'b0;
          ack_d[gid_q] = 1'b1;
          rr_d         = rr_next(gid_q);
          state_d      = RELEASE;
        end
`ifdef FB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          we_d         = 1'b0;
          err_d[gid_q] = 1'b1;
          rr_d         = rr_next(gid_q);
          state_d      = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        // Hold off the next write until the framebuffer drops its strobe.
        if (!bus.fb_w_data_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      din_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      gid_q   <= '0;
`ifdef FB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      x_q     <= x_d;
      y_q     <= y_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
`ifdef FB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.fb_we     = we_q;
  assign bus.fb_w_xpos = x_q;
  assign bus.fb_w_ypos = y_q;
  assign bus.fb_din    = din_q;
  assign bus.req_ack   = ack_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gid_q;
`ifdef FB_ARB_TIMEOUT_EN
  assign bus.req_err   = err_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a behavioural framebuffer responder.
module tb_fb_write_arbiter;
  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  fb_write_arbiter_if #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .DATA_W(DW)) bus ();

  fb_write_arbiter #(
    .NUM_REQ(N), .X_W(XW), .Y_W(YW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer responder settings and monitor state
  bit   resp_en   = 1'b1;
  int   resp_dly  = 1;
  int   resp_hold = 1;
  int   wcnt      = 0;
  int   hold_left = 0;
  int   ack_log[$];
  int   ack_cnt[N];
  int   overlap_err = 0;
  int   dbl_ack     = 0;
  int   multi_ack   = 0;
  logic prev_we     = 1'b0;
  logic [N-1:0] prev_ack = '0;

  initial begin
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fb_we && !prev_we && bus.fb_w_data_valid) overlap_err++;
      if ($countones(bus.req_ack) > 1) multi_ack++;
      for (int i = 0; i < N; i++) begin
        if (bus.req_ack[i]) begin
          ack_log.push_back(i);
          ack_cnt[i]++;
          if (prev_ack[i]) dbl_ack++;
        end
      end
    end
    prev_we  = bus.fb_we;
    prev_ack = bus.req_ack;
    if (rst) begin
      bus.fb_w_data_valid = 1'b0;
      wcnt = 0;
      hold_left = 0;
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) bus.fb_w_data_valid = 1'b0;
    end else if (bus.fb_we && resp_en) begin
      wcnt++;
      if (wcnt >= resp_dly) begin
        bus.fb_w_data_valid = 1'b1;
        hold_left = resp_hold;
        wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic wait_ack_count(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (ack_log.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Raise the masked requests and drop each one as it is acknowledged.
  task automatic serve(input logic [N-1:0] mask, input int budget, output bit ok);
    bus.req_valid = mask;
    for (int c = 0; c < budget && bus.req_valid != '0; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) if (bus.req_ack[i]) bus.req_valid[i] = 1'b0;
    end
    ok = (bus.req_valid == '0);
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_xpos[i*XW +: XW] = XW'(i * 16 + 1);
      bus.req_ypos[i*YW +: YW] = YW'(i * 4 + 3);
      bus.req_din[i*DW +: DW]  = DW'(8'hA0 + i);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (bus.fb_we !== 1'b0) begin fails++; $display("FAIL reset_fb_we got %b want 0", bus.fb_we); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.grant_id !== '0) begin fails++; $display("FAIL reset_grant_id got %0d want 0", bus.grant_id); end
    tests++; if (bus.req_ack !== '0) begin fails++; $display("FAIL reset_req_ack got %b want 0", bus.req_ack); end
    tests++; if ({bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din} !== '0) begin
      fails++; $display("FAIL reset_fb_bus got %h/%h/%h want 0/0/0", bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int  we_cnt = 1;
    bit  got = 1'b0;
    bus.req_xpos[0 +: XW] = 8'd5;
    bus.req_ypos[0 +: YW] = 8'd2;
    bus.req_din[0 +: DW]  = 8'hFF;
    resp_dly = 3; resp_hold = 1; resp_en = 1'b1;
    @(negedge clk); #1;
    bus.req_valid = 4'b0001;
    @(negedge clk); #1;
    tests++; if (bus.fb_we !== 1'b1) begin fails++; $display("FAIL single_we_latency got %b want 1", bus.fb_we); end
    tests++; if ({bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din} !== {8'd5, 8'd2, 8'hFF}) begin
      fails++; $display("FAIL single_fb_bus got %0d/%0d/%h want 5/2/ff", bus.fb_w_xpos, bus.fb_w_ypos, bus.fb_din);
    end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", bus.busy); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.req_ack != '0) begin got = 1'b1; break; end
      if (bus.fb_we) we_cnt++;
    end
    bus.req_valid = '0;
    tests++; if (!got) begin fails++; $display("FAIL single_ack_timeout got none want ack within 20 cycles"); end
    tests++; if (bus.req_ack !== 4'b0001) begin fails++; $display("FAIL single_ack got %b want 0001", bus.req_ack); end
    tests++; if (bus.fb_we !== 1'b0) begin fails++; $display("FAIL single_we_drop got %b want 0", bus.fb_we); end
    tests++; if (bus.grant_id !== 2'd0) begin fails++; $display("FAIL single_grant got %0d want 0", bus.grant_id); end
    tests++; if (we_cnt !== 3) begin fails++; $display("FAIL single_we_cycles got %0d want 3", we_cnt); end
    @(negedge clk); #1;
    tests++; if (bus.req_ack !== '0) begin fails++; $display("FAIL single_ack_pulse got %b want 0000", bus.req_ack); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n0;
    bit ok;
    resp_dly = 1; resp_hold = 1;
    rst = 1'b1; @(negedge clk); #1; rst = 1'b0;
    n0 = ack_log.size();
    for (int r = 0; r < 2; r++) begin
      serve(4'hF, 200, ok);
      tests++; if (!ok) begin fails++; $display("FAIL rr_round%0d_timeout got pending want all acked", r); end
    end
    tests++; if (ack_log.size() !== n0 + 8) begin fails++; $display("FAIL rr_ack_total got %0d want 8", ack_log.size() - n0); end
    for (int k = 0; k < 8 && n0 + k < ack_log.size(); k++) begin
      tests++; if (ack_log[n0+k] !== k % 4) begin
        fails++; $display("FAIL rr_order[%0d] got %0d want %0d", k, ack_log[n0+k], k % 4);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_two_requesters();
    int n0, a0, a2;
    bit ok;
    n0 = ack_log.size(); a0 = ack_cnt[0]; a2 = ack_cnt[2];
    bus.req_valid = 4'b1010;
    wait_ack_count(n0 + 8, 200, ok);
    bus.req_valid = '0;
    tests++; if (!ok) begin fails++; $display("FAIL alt_timeout got %0d acks want 8", ack_log.size() - n0); end
    for (int k = 0; k < 8 && n0 + k < ack_log.size(); k++) begin
      tests++; if (ack_log[n0+k] !== ((k % 2 == 0) ? 1 : 3)) begin
        fails++; $display("FAIL alt_order[%0d] got %0d want %0d", k, ack_log[n0+k], (k % 2 == 0) ? 1 : 3);
      end
    end
    tests++; if (ack_cnt[0] !== a0 || ack_cnt[2] !== a2) begin
      fails++; $display("FAIL alt_starved got %0d/%0d extra acks want 0/0", ack_cnt[0] - a0, ack_cnt[2] - a2);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int  n0, a1;
    bit  ok, up = 1'b0;
    resp_en = 1'b1;
    serve(4'b0100, 50, ok);
    repeat (3) @(negedge clk);
    resp_en = 1'b0;
    a1 = ack_cnt[1];
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.fb_we) begin up = 1'b1; break; end
    end
    tests++; if (!up) begin fails++; $display("FAIL areset_no_grant got fb_we 0 want 1"); end
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests++; if (bus.fb_we !== 1'b0) begin fails++; $display("FAIL areset_fb_we got %b want 0", bus.fb_we); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL areset_busy got %b want 0", bus.busy); end
    tests++; if (bus.grant_id !== '0) begin fails++; $display("FAIL areset_grant_id got %0d want 0", bus.grant_id); end
    bus.req_valid = '0;
    @(negedge clk); #1;
    rst = 1'b0;
    resp_en = 1'b1;
    n0 = ack_log.size();
    serve(4'b1100, 100, ok);
    tests++; if (!ok || ack_log.size() < n0 + 2) begin fails++; $display("FAIL areset_serve_timeout got %0d acks want 2", ack_log.size() - n0); end
    else begin
      tests++; if (ack_log[n0] !== 2) begin fails++; $display("FAIL areset_first_grant got %0d want 2", ack_log[n0]); end
      tests++; if (ack_log[n0+1] !== 3) begin fails++; $display("FAIL areset_second_grant got %0d want 3", ack_log[n0+1]); end
    end
    tests++; if (ack_cnt[1] !== a1) begin fails++; $display("FAIL areset_abandoned_ack got %0d want 0", ack_cnt[1] - a1); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_release_hold();
    int n0, hi = 0, viol = 0;
    bit ok, rose = 1'b0;
    resp_dly = 1; resp_hold = 5;
    n0 = ack_log.size();
    bus.req_valid = 4'b0001;
    wait_ack_count(n0 + 1, 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL hold_first_ack got none want ack"); end
    for (int c = 0; c < 20 && bus.fb_w_data_valid; c++) begin
      if (bus.fb_we !== 1'b0 || bus.busy !== 1'b1) viol++;
      hi++;
      @(negedge clk); #1;
    end
    tests++; if (viol !== 0) begin fails++; $display("FAIL hold_we_or_busy got %0d bad cycles want 0", viol); end
    tests++; if (hi !== 4) begin fails++; $display("FAIL hold_valid_cycles got %0d want 4", hi); end
    for (int c = 0; c < 10; c++) begin
      if (bus.fb_we) begin rose = 1'b1; break; end
      @(negedge clk); #1;
    end
    tests++; if (!rose) begin fails++; $display("FAIL hold_next_we got 0 want 1 after valid falls"); end
    wait_ack_count(n0 + 2, 50, ok);
    bus.req_valid = '0;
    tests++; if (!ok) begin fails++; $display("FAIL hold_second_ack got none want ack"); end
    resp_hold = 1;
    for (int c = 0; c < 20 && bus.busy; c++) begin @(negedge clk); #1; end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL hold_idle got busy %b want 0", bus.busy); end
  endtask

`ifdef FB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n0, a0, we_cnt = 0;
    bit up = 1'b0, ok;
    resp_en = 1'b0;
    a0 = ack_cnt[0];
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.fb_we) begin up = 1'b1; break; end
    end
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 40 && bus.fb_we; c++) begin
      we_cnt++;
      @(negedge clk); #1;
    end
    tests++; if (!up || we_cnt !== 16) begin fails++; $display("FAIL tmo_we_cycles got %0d want 16", we_cnt); end
    tests++; if (bus.req_err !== 4'b0001) begin fails++; $display("FAIL tmo_err got %b want 0001", bus.req_err); end
    tests++; if (bus.req_ack !== '0) begin fails++; $display("FAIL tmo_ack got %b want 0000", bus.req_ack); end
    bus.req_valid = 4'b0010;
    resp_en = 1'b1;
    @(negedge clk); #1;
    tests++; if (bus.req_err !== '0) begin fails++; $display("FAIL tmo_err_pulse got %b want 0000", bus.req_err); end
    n0 = ack_log.size();
    wait_ack_count(n0 + 1, 50, ok);
    bus.req_valid = '0;
    tests++; if (!ok || ack_log[n0] !== 1) begin fails++; $display("FAIL tmo_next_grant got %0d want 1", ok ? ack_log[n0] : -1); end
    tests++; if (ack_cnt[0] !== a0) begin fails++; $display("FAIL tmo_no_ack0 got %0d want 0", ack_cnt[0] - a0); end
    repeat (4) @(negedge clk);
  endtask
`endif

  task automatic test_protocol();
    tests++; if (overlap_err !== 0) begin fails++; $display("FAIL proto_we_overlap got %0d want 0", overlap_err); end
    tests++; if (dbl_ack !== 0) begin fails++; $display("FAIL proto_ack_width got %0d long pulses want 0", dbl_ack); end
    tests++; if (multi_ack !== 0) begin fails++; $display("FAIL proto_ack_onehot got %0d want 0", multi_ack); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got time limit want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_xpos  = '0;
    bus.req_ypos  = '0;
    bus.req_din   = '0;
    bus.fb_w_data_valid = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_two_requesters();
    test_async_reset();
    test_release_hold();
`ifdef FB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
